// File: rtl/mux_2to1_pkg.sv
// Shared definitions for the 2-to-1 data selector.
// Holds the select encoding used by the selector core and the top.
package mux_2to1_pkg;

    typedef logic sel_t;

    localparam sel_t SEL_IN0 = 1'b0;
    localparam sel_t SEL_IN1 = 1'b1;

endpackage

// File: rtl/mux_2to1_core.sv
// Combinational WIDTH-bit 2-to-1 selector; conditional operator keeps
// the usual X-merge behaviour when the select is unknown.
module mux_2to1_core
    import mux_2to1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  sel_t             sel,
    output logic [WIDTH-1:0] out
);

    assign out = (sel == SEL_IN1) ? in1 : in0;

endmodule

// File: rtl/mux_2to1.sv
// 2-to-1 data selector with a zero-latency output and a registered copy
// of the selected data plus a valid flag that clears on reset.
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_q_valid
);

    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] r_out_q;
    logic             r_out_q_valid;

    mux_2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in0 (in0),
        .in1 (in1),
        .sel (sel),
        .out (w_sel_data)
    );

    // Reset takes priority over the load enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q       <= RST_VAL;
            r_out_q_valid <= 1'b0;
        end else if (en) begin
            r_out_q       <= w_sel_data;
            r_out_q_valid <= 1'b1;
        end
    end

    assign out         = w_sel_data;
    assign out_q       = r_out_q;
    assign out_q_valid = r_out_q_valid;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed and randomised checks of mux_2to1 at WIDTH=1 and WIDTH=8;
// registered-path expectations flow through a scoreboard queue.
module tb_mux_2to1;

    typedef struct packed {
        logic [7:0] q;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_in0, a_in1, a_sel, a_en;
    logic       a_out, a_out_q, a_out_q_valid;

    logic [7:0] b_in0, b_in1, b_out, b_out_q;
    logic       b_sel, b_en, b_out_q_valid;

    int unsigned total = 0;
    int unsigned bad   = 0;

    exp_t       sb[$];
    logic [7:0] m_q;
    logic       m_v;

    always #5 clk = ~clk;

    mux_2to1 #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .in0         (a_in0),
        .in1         (a_in1),
        .sel         (a_sel),
        .en          (a_en),
        .out         (a_out),
        .out_q       (a_out_q),
        .out_q_valid (a_out_q_valid)
    );

    mux_2to1 #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in0         (b_in0),
        .in1         (b_in1),
        .sel         (b_sel),
        .en          (b_en),
        .out         (b_out),
        .out_q       (b_out_q),
        .out_q_valid (b_out_q_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected next registered state derived from current inputs, pushed before the edge.
    task automatic edge8(input string tag);
        exp_t e;
        exp_t got;
        if (rst) begin
            e.q = 8'h00;
            e.v = 1'b0;
        end else if (b_en) begin
            e.q = b_sel ? b_in1 : b_in0;
            e.v = 1'b1;
        end else begin
            e.q = m_q;
            e.v = m_v;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty got 0 expected 1", tag);
        end else begin
            got = sb.pop_front();
            check({tag, "_q"}, 64'(b_out_q), 64'(got.q));
            check({tag, "_v"}, 64'(b_out_q_valid), 64'(got.v));
            m_q = got.q;
            m_v = got.v;
        end
    endtask

    initial begin
        logic [7:0] exp_out;

        rst   = 1'b1;
        a_en  = 1'b0;
        a_in0 = 1'b0;
        a_in1 = 1'b0;
        a_sel = 1'b0;
        b_en  = 1'b0;
        b_sel = 1'b0;
        b_in0 = 8'h00;
        b_in1 = 8'h00;
        m_q   = 8'hxx;
        m_v   = 1'bx;

        // WIDTH=1 combinational path
        a_sel = 1'b1; a_in0 = 1'b0; a_in1 = 1'b1; #1;
        check("w1_sel1_a", 64'(a_out), 64'd1);
        a_in0 = 1'b1; a_in1 = 1'b0; #1;
        check("w1_sel1_b", 64'(a_out), 64'd0);
        a_sel = 1'b0; a_in0 = 1'b1; a_in1 = 1'b1; #1;
        check("w1_sel0_a", 64'(a_out), 64'd1);
        a_in1 = 1'b0; #1;
        check("w1_sel0_b", 64'(a_out), 64'd1);

        // Reset for one edge
        edge8("rst");
        check("w1_rst_q", 64'(a_out_q), 64'd0);
        check("w1_rst_v", 64'(a_out_q_valid), 64'd0);
        check("w8_rst_q_const", 64'(b_out_q), 64'h00);

        rst = 1'b0; b_en = 1'b1; b_sel = 1'b0; b_in0 = 8'hA5; b_in1 = 8'h3C; #1;
        check("w8_out_pre", 64'(b_out), 64'hA5);
        edge8("load_a5");
        check("w8_q_a5", 64'(b_out_q), 64'hA5);
        check("w8_v_a5", 64'(b_out_q_valid), 64'd1);

        b_sel = 1'b1; b_en = 1'b0; #1;
        check("w8_out_3c", 64'(b_out), 64'h3C);
        edge8("hold");
        check("w8_hold_a5", 64'(b_out_q), 64'hA5);

        b_en = 1'b1;
        edge8("load_3c");
        check("w8_q_3c", 64'(b_out_q), 64'h3C);

        // Reset mid-operation with en still high
        rst = 1'b1; #1;
        check("w8_out_in_rst", 64'(b_out), 64'h3C);
        edge8("midrst");
        check("w8_midrst_q", 64'(b_out_q), 64'h00);
        check("w8_midrst_v", 64'(b_out_q_valid), 64'd0);
        b_sel = 1'b0; #1;
        check("w8_out_in_rst2", 64'(b_out), 64'hA5);

        rst = 1'b0; b_en = 1'b0;
        edge8("post_rst_noen");
        check("w8_v_stays0", 64'(b_out_q_valid), 64'd0);

        // Equal inputs: output independent of select
        b_en = 1'b1; b_in0 = 8'h5A; b_in1 = 8'h5A;
        for (int s = 0; s < 2; s++) begin
            b_sel = s[0]; #1;
            check("w8_equal", 64'(b_out), 64'h5A);
            edge8("equal");
        end

        // Random pairs, both select values each
        for (int i = 0; i < 32; i++) begin
            b_in0 = 8'($urandom_range(0, 255));
            b_in1 = 8'($urandom_range(0, 255));
            for (int s = 0; s < 2; s++) begin
                b_sel = s[0]; #1;
                exp_out = s[0] ? b_in1 : b_in0;
                check("w8_rand_out", 64'(b_out), 64'(exp_out));
                edge8("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
